// File: rtl/half_adder_cell.sv
// Purpose : combinational 1-bit half adder cell, s = a ^ b, c = a & b.
// Latency : 0 cycles (purely combinational; no storage).
// Backpr. : none; the cell has no handshake and evaluates its inputs continuously.
//
// Ports:
//   a  input  1  addend A
//   b  input  1  addend B
//   s  output 1  sum bit   (a ^ b)
//   c  output 1  carry bit (a & b)
module half_adder_cell (
   input  logic a,
   input  logic b,
   output logic s,
   output logic c
);

   // Both outputs are fully assigned on every evaluation, so no latch is inferred.
   // X/Z on an input is deliberately left to propagate through ^ and &.
   always @* begin
      s = a ^ b;
      c = a & b;
   end

endmodule

// File: rtl/half_adder_bl.sv
// Purpose : registered WIDTH-lane half adder; lane i adds ip1[i] + ip2[i] with no cross-lane carry.
// Latency : exactly 1 clk cycle from operands to sum/carry; new operands accepted every cycle.
// Backpr. : none; there is no handshake or enable, the block never stalls its producer.
//
// Ports:
//   clk    input  1      sole clock, rising-edge active
//   rst    input  1      synchronous, active-high reset; clears sum and carry
//   ip1    input  WIDTH  addend A
//   ip2    input  WIDTH  addend B
//   sum    output WIDTH  registered lane sums   (ip1 ^ ip2)
//   carry  output WIDTH  registered lane carries (ip1 & ip2)
module half_adder_bl #(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] ip1,
   input  logic [WIDTH-1:0] ip2,
   output logic [WIDTH-1:0] sum,
   output logic [WIDTH-1:0] carry
);

   logic [WIDTH-1:0] sum_d;
   logic [WIDTH-1:0] carry_d;
   logic [WIDTH-1:0] sum_q;
   logic [WIDTH-1:0] carry_q;

   // One independent cell per lane; lanes never exchange carries.
   for (genvar i = 0; i < WIDTH; i++) begin : g_lane
      half_adder_cell u_cell (
         .a (ip1[i]),
         .b (ip2[i]),
         .s (sum_d[i]),
         .c (carry_d[i])
      );
   end

   // Single output register pair. Reset takes priority and discards the operands
   // presented on the reset edge. No reset value exists before the first rst edge,
   // so the outputs are X until then.
   always_ff @(posedge clk) begin
      if (rst) begin
         sum_q   <= '0;
         carry_q <= '0;
      end else begin
         sum_q   <= sum_d;
         carry_q <= carry_d;
      end
   end

   // Outputs come only from flops: no combinational input-to-output path.
   assign sum   = sum_q;
   assign carry = carry_q;

endmodule

// File: tb/tb_half_adder_bl.sv
module tb_half_adder_bl;

   logic       clk = 1'b0;
   logic       rst;
   logic       ip1_1, ip2_1, sum_1, carry_1;
   logic [3:0] ip1_4, ip2_4, sum_4, carry_4;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   half_adder_bl u_dut1 (
      .clk   (clk),
      .rst   (rst),
      .ip1   (ip1_1),
      .ip2   (ip2_1),
      .sum   (sum_1),
      .carry (carry_1)
   );

   half_adder_bl #(.WIDTH(4)) u_dut4 (
      .clk   (clk),
      .rst   (rst),
      .ip1   (ip1_4),
      .ip2   (ip2_4),
      .sum   (sum_4),
      .carry (carry_4)
   );

   // Reference: each lane is an arithmetic 1-bit + 1-bit = 2-bit addition.
   // Returns {carry[3:0], sum[3:0]}.
   function automatic logic [7:0] ref_add4(input logic [3:0] a, input logic [3:0] b);
      logic [3:0] s;
      logic [3:0] c;
      for (int i = 0; i < 4; i++) begin
         int t;
         t    = int'(a[i]) + int'(b[i]);
         s[i] = (t % 2) == 1;
         c[i] = (t / 2) == 1;
      end
      return {c, s};
   endfunction

   // Returns {carry, sum} for a single lane.
   function automatic logic [1:0] ref_add1(input logic a, input logic b);
      int t;
      t = int'(a) + int'(b);
      return 2'(t);
   endfunction

   // Sample 1 time unit after the rising edge, inputs are driven at the same point.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst   = 1'b1;
      ip1_1 = 1'b1;
      ip2_1 = 1'b1;
      ip1_4 = 4'hF;
      ip2_4 = 4'hF;
      for (int e = 0; e < 2; e++) begin
         tick();
         checks++;
         if ({carry_1, sum_1} !== 2'b00) begin
            errors++;
            $display("FAIL reset_w1 edge%0d: got carry,sum=%b%b expected 00", e, carry_1, sum_1);
         end
         checks++;
         if ({carry_4, sum_4} !== 8'h00) begin
            errors++;
            $display("FAIL reset_w4 edge%0d: got carry=%b sum=%b expected 0000/0000", e, carry_4, sum_4);
         end
      end
   endtask

   task automatic test_exhaustive();
      logic [1:0] v;
      logic [1:0] exp;
      rst = 1'b0;
      for (int k = 0; k < 4; k++) begin
         v     = 2'(k);
         ip1_1 = v[1];
         ip2_1 = v[0];
         exp   = ref_add1(v[1], v[0]);
         tick();
         checks++;
         if ({carry_1, sum_1} !== exp) begin
            errors++;
            $display("FAIL exhaustive ip=%b: got carry,sum=%b%b expected %b", v, carry_1, sum_1, exp);
         end
      end
   endtask

   task automatic test_latency();
      rst   = 1'b0;
      ip1_1 = 1'b1;
      ip2_1 = 1'b1;
      tick();
      checks++;
      if ({carry_1, sum_1} !== 2'b10) begin
         errors++;
         $display("FAIL latency_first: got carry,sum=%b%b expected 10", carry_1, sum_1);
      end
      // Operands change mid-cycle; registered outputs must hold until the next edge.
      ip1_1 = 1'b0;
      ip2_1 = 1'b0;
      #2;
      checks++;
      if ({carry_1, sum_1} !== 2'b10) begin
         errors++;
         $display("FAIL latency_hold: got carry,sum=%b%b expected 10", carry_1, sum_1);
      end
      tick();
      checks++;
      if ({carry_1, sum_1} !== 2'b00) begin
         errors++;
         $display("FAIL latency_clear: got carry,sum=%b%b expected 00", carry_1, sum_1);
      end
   endtask

   task automatic test_reset_mid();
      rst   = 1'b0;
      ip1_1 = 1'b1;
      ip2_1 = 1'b1;
      tick();
      checks++;
      if (carry_1 !== 1'b1) begin
         errors++;
         $display("FAIL midrst_pre: got carry=%b expected 1", carry_1);
      end
      rst = 1'b1;
      tick();
      checks++;
      if ({carry_1, sum_1} !== 2'b00) begin
         errors++;
         $display("FAIL midrst_reset: got carry,sum=%b%b expected 00", carry_1, sum_1);
      end
      rst   = 1'b0;
      ip1_1 = 1'b0;
      ip2_1 = 1'b1;
      tick();
      checks++;
      if ({carry_1, sum_1} !== 2'b01) begin
         errors++;
         $display("FAIL midrst_resume: got carry,sum=%b%b expected 01", carry_1, sum_1);
      end
   endtask

   task automatic test_width4();
      logic [7:0] exp;
      rst   = 1'b0;
      ip1_4 = 4'b1100;
      ip2_4 = 4'b1010;
      exp   = ref_add4(ip1_4, ip2_4);
      tick();
      checks++;
      if (sum_4 !== 4'b0110 || sum_4 !== exp[3:0]) begin
         errors++;
         $display("FAIL width4_sum: got %b expected 0110", sum_4);
      end
      checks++;
      if (carry_4 !== 4'b1000 || carry_4 !== exp[7:4]) begin
         errors++;
         $display("FAIL width4_carry: got %b expected 1000", carry_4);
      end
   endtask

   // Random operands (with occasional reset) on both instances; the expected result
   // is computed when the operands are applied and compared one edge later.
   task automatic test_random();
      logic [1:0] exp1;
      logic [7:0] exp4;
      for (int n = 0; n < 1000; n++) begin
         rst   = ($urandom_range(0, 19) == 0);
         ip1_1 = 1'($urandom);
         ip2_1 = 1'($urandom);
         ip1_4 = 4'($urandom);
         ip2_4 = 4'($urandom);
         exp1  = rst ? 2'b00 : ref_add1(ip1_1, ip2_1);
         exp4  = rst ? 8'h00 : ref_add4(ip1_4, ip2_4);
         tick();
         checks++;
         if ({carry_1, sum_1} !== exp1) begin
            errors++;
            $display("FAIL random_w1 #%0d: got carry,sum=%b%b expected %b", n, carry_1, sum_1, exp1);
         end
         checks++;
         if ({carry_4, sum_4} !== exp4) begin
            errors++;
            $display("FAIL random_w4 #%0d: got carry=%b sum=%b expected carry=%b sum=%b",
                     n, carry_4, sum_4, exp4[7:4], exp4[3:0]);
         end
      end
      rst = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst   = 1'b0;
      ip1_1 = 1'b0;
      ip2_1 = 1'b0;
      ip1_4 = 4'h0;
      ip2_4 = 4'h0;
      #2;
      test_reset();
      test_exhaustive();
      test_latency();
      test_reset_mid();
      test_width4();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
